// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR random-byte server.
//   DEFAULT_SEED : LFSR value after reset and the lock-up replacement value
//   TAP_MASK     : feedback taps {7,3,2,1} of the 8-bit many-to-one LFSR
//   state_e      : server FSM states
//   lfsr_next()  : one LFSR step, next = {s[6:0], s[7]^s[3]^s[2]^s[1]}
package lfsr_pkg;

   localparam logic [7:0] DEFAULT_SEED = 8'hBD;
   localparam logic [7:0] TAP_MASK     = 8'b1000_1110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GRANT = 2'd2
   } state_e;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & TAP_MASK)};
   endfunction

endpackage

// File: rtl/lfsr8_core.sv
// lfsr8_core: 8-bit many-to-one LFSR register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (state -> DEFAULT_SEED)
//   load       : load load_val (has priority over shift)
//   load_val   : value to load
//   shift      : advance one step
//   state      : current LFSR value
// Build option: LFSR_LOCKUP_GUARD_EN replaces an all-zero seed, and an
// all-zero state found while shifting, with DEFAULT_SEED.
module lfsr8_core
   import lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       shift,
   output logic [7:0] state
);

   logic [7:0] w_load_val;
   logic [7:0] w_shift_val;

`ifdef LFSR_LOCKUP_GUARD_EN
   assign w_load_val  = (load_val == '0) ? DEFAULT_SEED : load_val;
   assign w_shift_val = (state == '0) ? DEFAULT_SEED : lfsr_next(state);
`else
   assign w_load_val  = load_val;
   assign w_shift_val = lfsr_next(state);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= DEFAULT_SEED;
      else if (load)
         state <= w_load_val;
      else if (shift)
         state <= w_shift_val;
   end

endmodule

// File: rtl/lfsr_rand_server.sv
// lfsr_rand_server: round-robin server handing out LFSR random bytes.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester level request, held until gnt
//   seed_load  : strobe loading seed_val into the LFSR, aborts a pending SHIFT
//   seed_val   : seed value
//   gnt        : one-hot single-cycle grant
//   rnd        : random byte, valid with gnt and held until the next grant
//   busy       : high whenever the FSM is not IDLE
// Build option: LFSR_LOCKUP_GUARD_EN (see lfsr8_core).
module lfsr_rand_server
   import lfsr_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned STEPS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             seed_load,
   input  logic [7:0]       seed_val,
   output logic [N_REQ-1:0] gnt,
   output logic [7:0]       rnd,
   output logic             busy
);

   localparam int unsigned    PW        = $clog2(N_REQ);
   localparam logic [PW-1:0]  LAST_REQ  = PW'(N_REQ - 1);
   localparam logic [7:0]     LAST_STEP = 8'(STEPS - 1);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_win;
   logic [7:0]    r_cnt;
   logic [7:0]    r_rnd;
   logic [7:0]    w_lfsr;
   logic          w_any;
   logic          w_hi_found;
   logic [PW-1:0] w_hi;
   logic [PW-1:0] w_lo;
   logic [PW-1:0] w_win;

   lfsr8_core u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (seed_val),
      .shift    (r_state == ST_SHIFT),
      .state    (w_lfsr)
   );

   // Round-robin with wrap: lowest set bit at or above ptr, otherwise the
   // lowest set bit overall.
   always_comb begin
      w_any      = 1'b0;
      w_hi_found = 1'b0;
      w_hi       = '0;
      w_lo       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req[PW'(i)]) begin
            if (!w_hi_found && (PW'(i) >= r_ptr)) begin
               w_hi_found = 1'b1;
               w_hi       = PW'(i);
            end
            if (!w_any) begin
               w_any = 1'b1;
               w_lo  = PW'(i);
            end
         end
      end
      w_win = w_hi_found ? w_hi : w_lo;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (!seed_load && w_any) w_state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (seed_load)
               w_state_nxt = ST_IDLE;
            else if (r_cnt == LAST_STEP)
               w_state_nxt = ST_GRANT;
         end
         ST_GRANT: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_cnt   <= '0;
         r_rnd   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (!seed_load && w_any)
                  r_win <= w_win;
            end
            ST_SHIFT: r_cnt <= r_cnt + 8'd1;
            // Grant completes even when a seed load arrives this cycle;
            // the byte held afterwards is the pre-seed LFSR value.
            ST_GRANT: begin
               r_rnd <= w_lfsr;
               r_ptr <= (r_win == LAST_REQ) ? '0 : r_win + PW'(1);
            end
            default: ;
         endcase
      end
   end

   assign gnt  = (r_state == ST_GRANT) ? (N_REQ'(1) << r_win) : '0;
   assign rnd  = (r_state == ST_GRANT) ? w_lfsr : r_rnd;
   assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lfsr_rand_server.sv
// tb_lfsr_rand_server: randomized self-checking bench for lfsr_rand_server
// with a transaction-level reference model (round-robin pick, LFSR byte
// after STEPS steps, pointer, LFSR contents).
module tb_lfsr_rand_server;

   localparam int unsigned N     = 4;
   localparam int unsigned STEPS = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic         seed_load;
   logic [7:0]   seed_val;
   logic [N-1:0] gnt;
   logic [7:0]   rnd;
   logic         busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [7:0]  m_lfsr;
   int unsigned m_ptr;
   logic [7:0]  m_rnd;

   lfsr_rand_server #(.N_REQ(N), .STEPS(STEPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .gnt       (gnt),
      .rnd       (rnd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic guard_on();
`ifdef LFSR_LOCKUP_GUARD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] seeded(input logic [7:0] v);
      return (guard_on() && v == 8'h00) ? 8'hBD : v;
   endfunction

   function automatic logic [7:0] advance(input logic [7:0] s0, input int unsigned n);
      logic [7:0] s = s0;
      for (int unsigned k = 0; k < n; k++) begin
         if (guard_on() && s == 8'h00) s = 8'hBD;
         else s = {s[6:0], s[1] ^ s[2] ^ s[3] ^ s[7]};
      end
      return s;
   endfunction

   function automatic int unsigned rr_pick(input logic [N-1:0] m, input int unsigned p);
      for (int unsigned k = 0; k < N; k++) begin
         int unsigned idx = (p + k) % N;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   // Called at a negedge with rst_n low already driven.
   task automatic apply_reset();
      rst_n = 1'b0; req = '0; seed_load = 1'b0; seed_val = '0;
      @(posedge clk); @(negedge clk);
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_rnd", rnd, 0);
      check_eq("rst_busy", busy, 0);
      rst_n = 1'b1;
      m_lfsr = 8'hBD; m_ptr = 0; m_rnd = 8'h00;
   endtask

   // Starts and ends at a negedge with the DUT idle. Optionally loads a seed
   // during the grant cycle.
   task automatic do_txn(input logic [N-1:0] mask, input logic seed_in_grant, input logic [7:0] sv);
      int unsigned w;
      logic [7:0]  exp_rnd;
      w       = rr_pick(mask, m_ptr);
      exp_rnd = advance(m_lfsr, STEPS);
      req = mask;
      @(posedge clk);
      for (int unsigned k = 0; k < STEPS; k++) begin
         @(negedge clk);
         check_eq("shift_busy", busy, 1);
         check_eq("shift_gnt", gnt, 0);
         @(posedge clk);
      end
      @(negedge clk);
      check_eq("grant_gnt", gnt, N'(1) << w);
      check_eq("grant_rnd", rnd, exp_rnd);
      check_eq("grant_busy", busy, 1);
      req = req & ~(N'(1) << w);
      m_ptr = (w + 1) % N;
      m_rnd = exp_rnd;
      if (seed_in_grant) begin
         seed_load = 1'b1; seed_val = sv;
         m_lfsr = seeded(sv);
      end else begin
         m_lfsr = exp_rnd;
      end
      @(posedge clk); @(negedge clk);
      seed_load = 1'b0;
      check_eq("after_busy", busy, 0);
      check_eq("after_gnt", gnt, 0);
      check_eq("after_rnd", rnd, m_rnd);
   endtask

   // seed_load together with a request in IDLE: only the seed is taken.
   task automatic seed_idle(input logic [N-1:0] mask, input logic [7:0] sv);
      req = mask; seed_load = 1'b1; seed_val = sv;
      @(posedge clk); @(negedge clk);
      seed_load = 1'b0;
      check_eq("seed_idle_busy", busy, 0);
      check_eq("seed_idle_gnt", gnt, 0);
      m_lfsr = seeded(sv);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; seed_load = 1'b0; seed_val = '0;
      @(negedge clk);
      apply_reset();

      // Single request from reset: rnd is the default seed after 8 steps.
      check_eq("model_first_byte", advance(m_lfsr, STEPS), 8'hBE);
      do_txn(4'b0001, 1'b0, 8'h00);

      // All requesters held: rotating grants.
      apply_reset();
      for (int unsigned k = 0; k < 5; k++) do_txn(4'b1111, 1'b0, 8'h00);

      // Wrap from a high winner.
      apply_reset();
      do_txn(4'b0100, 1'b0, 8'h00);
      do_txn(4'b0101, 1'b0, 8'h00);

      // Seed load at SHIFT step 3 aborts the grant.
      apply_reset();
      req = 4'b0001;
      @(posedge clk);
      for (int unsigned k = 0; k < 3; k++) begin
         @(posedge clk);
      end
      @(negedge clk);
      seed_load = 1'b1; seed_val = 8'h5A;
      check_eq("abort_gnt_pre", gnt, 0);
      @(posedge clk); @(negedge clk);
      seed_load = 1'b0;
      check_eq("abort_gnt", gnt, 0);
      check_eq("abort_busy", busy, 0);
      m_lfsr = 8'h5A;
      do_txn(4'b0001, 1'b0, 8'h00);

      // Zero seed: lock-up guard behaviour.
      seed_idle(4'b0001, 8'h00);
      m_ptr = 0;
      apply_reset();
      seed_idle(4'b0001, 8'h00);
      do_txn(4'b0001, 1'b0, 8'h00);
      check_eq("zero_seed_rnd", rnd, guard_on() ? 32'hBE : 32'h00);

      // Seed load during grant: grant completes, LFSR takes the seed.
      apply_reset();
      do_txn(4'b0010, 1'b1, 8'h3C);
      do_txn(4'b1010, 1'b0, 8'h00);

      // Reset mid-SHIFT.
      req = 4'b1000;
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; req = '0;
      @(posedge clk); @(negedge clk);
      check_eq("midrst_gnt", gnt, 0);
      check_eq("midrst_rnd", rnd, 0);
      check_eq("midrst_busy", busy, 0);
      rst_n = 1'b1;
      m_lfsr = 8'hBD; m_ptr = 0; m_rnd = 8'h00;
      for (int unsigned k = 0; k < STEPS + 2; k++) begin
         @(negedge clk);
         check_eq("midrst_quiet", gnt, 0);
      end
      do_txn(4'b0011, 1'b0, 8'h00);

      // Randomized mix.
      for (int unsigned it = 0; it < 30; it++) begin
         int unsigned op = $urandom_range(0, 9);
         logic [7:0]  sv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
         logic [N-1:0] m = N'($urandom_range(1, 15));
         if (op == 0) begin
            seed_idle(m, sv);
            do_txn(m, 1'b0, 8'h00);
         end else if (op == 1) begin
            do_txn(m, 1'b1, sv);
         end else begin
            do_txn(m, 1'b0, 8'h00);
         end
      end

      req = '0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
